// File: rtl/imem_responder.sv
// imem_responder
//   The memory end of the instruction-fetch interface. It accepts one fetch at a
//   time on a valid/ready channel. After LATENCY cycles it returns the addressed
//   32-bit word, or a NOP with the error flag set when the fetch address is
//   misaligned or out of range. A side write port loads the program image.
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous active-low reset
//   io_req_valid   fetch request valid
//   io_req_ready   responder can accept a request (combinational)
//   io_req_addr    fetch byte address
//   io_resp_valid  response valid (registered)
//   io_resp_ready  fetch stage accepts the response
//   io_resp_data   instruction word (registered)
//   io_resp_err    misaligned / out-of-range fetch (registered)
//   io_flush       kill the outstanding request (redirect)
//   io_wr_en       program-load write strobe
//   io_wr_addr     program-load byte address
//   io_wr_data     program-load data
//
// State table
//   IDLE | nothing outstanding, ready for a fetch
//   WAIT | fetch accepted, latency counter running
//   RESP | response presented, waiting for io_resp_ready

module imem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic [31:0] io_req_addr,
  output logic        io_resp_valid,
  input  logic        io_resp_ready,
  output logic [31:0] io_resp_data,
  output logic        io_resp_err,
  input  logic        io_flush,
  input  logic        io_wr_en,
  input  logic [31:0] io_wr_addr,
  input  logic [31:0] io_wr_data
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Instruction store (not reset)
  // ---------------------------------------------------------------------------
  logic [31:0] mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Address decode for the fetch and write ports. The subtraction is done one
  // bit wider so the borrow flags addresses below BASE_ADDR.
  // ---------------------------------------------------------------------------
  logic [32:0] rd_diff;
  logic [31:0] rd_off;
  logic        rd_below;
  logic        rd_ok;
  logic [31:0] rd_word;

  logic [32:0] wr_diff;
  logic [31:0] wr_off;
  logic        wr_below;
  logic        wr_ok;

  always_comb begin
    rd_diff  = {1'b0, io_req_addr} - {1'b0, BASE_ADDR};
    rd_off   = rd_diff[31:0];
    rd_below = rd_diff[32];
    rd_ok    = !rd_below && (rd_off[1:0] == 2'b00) &&
               ({2'b00, rd_off[31:2]} < DEPTH_W);
    rd_word  = rd_ok ? mem_q[rd_off[AW+1:2]] : NOP_WORD;
  end

  always_comb begin
    wr_diff  = {1'b0, io_wr_addr} - {1'b0, BASE_ADDR};
    wr_off   = wr_diff[31:0];
    wr_below = wr_diff[32];
    wr_ok    = io_wr_en && !wr_below && (wr_off[1:0] == 2'b00) &&
               ({2'b00, wr_off[31:2]} < DEPTH_W);
  end

  // The read above sees the pre-edge contents, so a write and an accept to the
  // same word in one cycle returns the old word.
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem_q[wr_off[AW+1:2]] <= io_wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;
  logic        accept;

  // In RESP the slot frees up in the same cycle as the handshake, so a new
  // fetch can be taken back-to-back.
  always_comb begin
    io_req_ready = 1'b0;
    if (!io_flush) begin
      case (state_q)
        IDLE:    io_req_ready = 1'b1;
        RESP:    io_req_ready = io_resp_ready;
        default: io_req_ready = 1'b0;
      endcase
    end
  end

  assign accept = io_req_valid && io_req_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;

    if (io_flush && (state_q != IDLE)) begin
      // A flush drops the pending response, even if it is being handshaken.
      state_d      = IDLE;
      resp_valid_d = 1'b0;
      cnt_d        = 4'd0;
    end else if (accept) begin
      resp_data_d = rd_word;
      resp_err_d  = !rd_ok;
      cnt_d       = LAT_LOAD;
      if (LATENCY > 1) begin
        state_d      = WAIT;
        resp_valid_d = 1'b0;
      end else begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
    end else begin
      case (state_q)
        WAIT: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end
        end
        RESP: begin
          if (io_resp_ready) begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
          end
        end
        default: begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign io_resp_valid = resp_valid_q;
  assign io_resp_data  = resp_data_q;
  assign io_resp_err   = resp_err_q;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic [1:0]       req_valid  = '0;
  logic [1:0][31:0] req_addr   = '0;
  logic [1:0]       resp_ready = '0;
  logic [1:0]       flush      = '0;
  logic [1:0]       wr_en      = '0;
  logic [1:0][31:0] wr_addr    = '0;
  logic [1:0][31:0] wr_data    = '0;
  logic [1:0]       req_ready;
  logic [1:0]       resp_valid;
  logic [1:0][31:0] resp_data;
  logic [1:0]       resp_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  imem_responder #(.DEPTH(1024), .LATENCY(LAT0), .BASE_ADDR(32'h0)) u_dut0 (
    .clock(clock), .reset(reset),
    .io_req_valid(req_valid[0]), .io_req_ready(req_ready[0]), .io_req_addr(req_addr[0]),
    .io_resp_valid(resp_valid[0]), .io_resp_ready(resp_ready[0]),
    .io_resp_data(resp_data[0]), .io_resp_err(resp_err[0]),
    .io_flush(flush[0]),
    .io_wr_en(wr_en[0]), .io_wr_addr(wr_addr[0]), .io_wr_data(wr_data[0])
  );

  imem_responder #(.DEPTH(1024), .LATENCY(LAT1), .BASE_ADDR(32'h0)) u_dut1 (
    .clock(clock), .reset(reset),
    .io_req_valid(req_valid[1]), .io_req_ready(req_ready[1]), .io_req_addr(req_addr[1]),
    .io_resp_valid(resp_valid[1]), .io_resp_ready(resp_ready[1]),
    .io_resp_data(resp_data[1]), .io_resp_err(resp_err[1]),
    .io_flush(flush[1]),
    .io_wr_en(wr_en[1]), .io_wr_addr(wr_addr[1]), .io_wr_data(wr_data[1])
  );

  // ---------------- behavioural model ----------------
  // A fetch is "outstanding" from its accept until handshake or flush; its
  // response is visible once age (edges since accept) reaches the latency.
  logic [31:0] m_mem [2][1024];
  bit          m_busy [2];
  int          m_age  [2];
  logic [31:0] m_data [2];
  logic        m_err  [2];

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'd4096);
  endfunction

  function automatic bit exp_valid(input int i);
    return m_busy[i] && (m_age[i] >= lat_of(i));
  endfunction

  function automatic bit exp_ready(input int i);
    return !flush[i] && (!m_busy[i] || (exp_valid(i) && resp_ready[i]));
  endfunction

  always @(negedge reset) begin
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0;
      m_age[i]  = 0;
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        bit v, r;
        v = exp_valid(i);
        r = exp_ready(i);
        if (flush[i] && m_busy[i]) begin
          m_busy[i] = 1'b0;
        end else if (req_valid[i] && r) begin
          m_busy[i] = 1'b1;
          m_age[i]  = 1;
          m_err[i]  = !legal(req_addr[i]);
          m_data[i] = legal(req_addr[i]) ? m_mem[i][req_addr[i] / 4] : 32'h13;
        end else if (v && resp_ready[i]) begin
          m_busy[i] = 1'b0;
        end else if (m_busy[i] && (m_age[i] < lat_of(i))) begin
          m_age[i] = m_age[i] + 1;
        end
        if (wr_en[i] && legal(wr_addr[i])) m_mem[i][wr_addr[i] / 4] = wr_data[i];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model_ready%0d", i), {31'b0, req_ready[i]}, {31'b0, exp_ready(i)});
      chk($sformatf("model_valid%0d", i), {31'b0, resp_valid[i]}, {31'b0, exp_valid(i)});
      if (exp_valid(i)) begin
        chk($sformatf("model_data%0d", i), resp_data[i], m_data[i]);
        chk($sformatf("model_err%0d", i), {31'b0, resp_err[i]}, {31'b0, m_err[i]});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clock);
    #2;
  endtask

  // Counts negedges from just after the accept edge until resp_valid.
  task automatic wait_resp(input int i, input string name, input logic [31:0] ed,
                           input logic ee, input int en);
    int n = 0;
    bit seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clock);
      if (resp_valid[i]) begin
        seen = 1;
        n = k;
      end
    end
    chk({name, "_lat"}, n, en);
    if (seen) begin
      chk({name, "_data"}, resp_data[i], ed);
      chk({name, "_err"}, {31'b0, resp_err[i]}, {31'b0, ee});
    end
  endtask

  task automatic fetch_lit(input int i, input string name, input logic [31:0] a,
                           input logic [31:0] ed, input logic ee);
    step();
    req_valid[i]  = 1'b1;
    req_addr[i]   = a;
    resp_ready[i] = 1'b1;
    @(posedge clock);
    #1 req_valid[i] = 1'b0;
    wait_resp(i, name, ed, ee, lat_of(i));
  endtask

  task automatic write_both(input logic [31:0] a, input logic [31:0] d);
    step();
    wr_en      = 2'b11;
    wr_addr[0] = a; wr_addr[1] = a;
    wr_data[0] = d; wr_data[1] = d;
    step();
    wr_en = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  logic [31:0] prog [4] = '{32'h00500093, 32'h00108113, 32'h002081B3, 32'h00000013};

  initial begin
    #3;
    chk("rst_valid", {31'b0, resp_valid[0]}, 32'd0);
    chk("rst_data",  resp_data[0], 32'd0);
    chk("rst_err",   {31'b0, resp_err[0]}, 32'd0);
    chk("rst_ready", {31'b0, req_ready[0]}, 32'd1);
    step();
    reset = 1'b1;

    for (int k = 0; k < 4; k++) write_both(k * 4, prog[k]);

    fetch_lit(0, "f0", 32'h0, 32'h00500093, 1'b0);

    // LATENCY=1: one fetch per cycle
    step();
    req_valid[1] = 1'b1; req_addr[1] = 32'h0; resp_ready[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1;
      if (k < 3) req_addr[1] = (k + 1) * 4;
      else req_valid[1] = 1'b0;
      @(negedge clock);
      chk($sformatf("pipe_valid%0d", k), {31'b0, resp_valid[1]}, 32'd1);
      chk($sformatf("pipe_data%0d", k), resp_data[1], prog[k]);
      if (k < 3) chk($sformatf("pipe_ready%0d", k), {31'b0, req_ready[1]}, 32'd1);
    end

    fetch_lit(0, "misal", 32'h6, 32'h13, 1'b1);
    fetch_lit(0, "range", 32'h1000, 32'h13, 1'b1);
    fetch_lit(1, "range1", 32'h1000, 32'h13, 1'b1);
    fetch_lit(0, "unchg", 32'h4, 32'h00108113, 1'b0);

    write_both(32'hFFC, 32'hCAFEF00D);
    write_both(32'h1000, 32'hBAD00BAD);
    write_both(32'h2, 32'h55555555);
    fetch_lit(0, "last", 32'hFFC, 32'hCAFEF00D, 1'b0);
    fetch_lit(0, "w0kept", 32'h0, 32'h00500093, 1'b0);
    fetch_lit(1, "last1", 32'hFFC, 32'hCAFEF00D, 1'b0);

    // backpressure
    step();
    req_valid[0] = 1'b1; req_addr[0] = 32'h8; resp_ready[0] = 1'b0;
    @(posedge clock);
    #1 req_valid[0] = 1'b0;
    wait_resp(0, "bp", 32'h002081B3, 1'b0, LAT0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_hold_data", resp_data[0], 32'h002081B3);
      chk("bp_hold_err", {31'b0, resp_err[0]}, 32'd0);
      chk("bp_ready", {31'b0, req_ready[0]}, 32'd0);
    end
    #2;
    resp_ready[0] = 1'b1; req_valid[0] = 1'b1; req_addr[0] = 32'h4;
    #1 chk("bp_ready_hi", {31'b0, req_ready[0]}, 32'd1);
    @(posedge clock);
    #1 req_valid[0] = 1'b0;
    wait_resp(0, "bp_next", 32'h00108113, 1'b0, LAT0);

    // flush one cycle after accept
    step();
    req_valid[0] = 1'b1; req_addr[0] = 32'h8; resp_ready[0] = 1'b1;
    @(posedge clock);
    #1 req_valid[0] = 1'b0;
    step();
    flush[0] = 1'b1;
    @(posedge clock);
    #1 flush[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk("flush_novalid", {31'b0, resp_valid[0]}, 32'd0);
    end
    fetch_lit(0, "after_flush", 32'hC, 32'h13, 1'b0);

    // flush while presenting, with resp_ready high
    step();
    req_valid[0] = 1'b1; req_addr[0] = 32'h0; resp_ready[0] = 1'b0;
    @(posedge clock);
    #1 req_valid[0] = 1'b0;
    wait_resp(0, "fl_resp", 32'h00500093, 1'b0, LAT0);
    #2;
    resp_ready[0] = 1'b1; flush[0] = 1'b1;
    #1 chk("fl_resp_ready", {31'b0, req_ready[0]}, 32'd0);
    @(posedge clock);
    #1 flush[0] = 1'b0;
    @(negedge clock);
    chk("fl_resp_drop", {31'b0, resp_valid[0]}, 32'd0);

    // flush in IDLE blocks accept
    step();
    req_valid[0] = 1'b1; req_addr[0] = 32'h4; flush[0] = 1'b1;
    #1 chk("fl_idle_ready", {31'b0, req_ready[0]}, 32'd0);
    @(posedge clock);
    #1 begin req_valid[0] = 1'b0; flush[0] = 1'b0; end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("fl_idle_novalid", {31'b0, resp_valid[0]}, 32'd0);
    end

    // same-cycle write and fetch of one word
    step();
    wr_en[0] = 1'b1; wr_addr[0] = 32'h4; wr_data[0] = 32'hDEADBEEF;
    req_valid[0] = 1'b1; req_addr[0] = 32'h4; resp_ready[0] = 1'b1;
    @(posedge clock);
    #1 begin wr_en[0] = 1'b0; req_valid[0] = 1'b0; end
    wait_resp(0, "rbw", 32'h00108113, 1'b0, LAT0);
    fetch_lit(0, "rbw_new", 32'h4, 32'hDEADBEEF, 1'b0);

    // write during WAIT leaves the latched response alone
    step();
    req_valid[0] = 1'b1; req_addr[0] = 32'h0; resp_ready[0] = 1'b1;
    @(posedge clock);
    #1 begin
      req_valid[0] = 1'b0;
      wr_en[0] = 1'b1; wr_addr[0] = 32'h0; wr_data[0] = 32'h11111111;
    end
    @(posedge clock);
    #1 wr_en[0] = 1'b0;
    wait_resp(0, "wr_wait", 32'h00500093, 1'b0, 1);
    fetch_lit(0, "wr_wait_new", 32'h0, 32'h11111111, 1'b0);

    // reset during WAIT
    step();
    req_valid[0] = 1'b1; req_addr[0] = 32'h8; resp_ready[0] = 1'b1;
    @(posedge clock);
    #1 req_valid[0] = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_wait_valid", {31'b0, resp_valid[0]}, 32'd0);
    chk("rst_wait_ready", {31'b0, req_ready[0]}, 32'd1);
    step();
    reset = 1'b1;

    // reset while presenting
    step();
    req_valid[0] = 1'b1; req_addr[0] = 32'h8; resp_ready[0] = 1'b0;
    @(posedge clock);
    #1 req_valid[0] = 1'b0;
    wait_resp(0, "pre_rst", 32'h002081B3, 1'b0, LAT0);
    #2 reset = 1'b0;
    #1;
    chk("rst_resp_valid", {31'b0, resp_valid[0]}, 32'd0);
    chk("rst_resp_ready", {31'b0, req_ready[0]}, 32'd1);
    chk("rst_resp_data", resp_data[0], 32'd0);
    step();
    reset = 1'b1;
    resp_ready[0] = 1'b1;

    fetch_lit(0, "mem_kept", 32'h8, 32'h002081B3, 1'b0);
    fetch_lit(1, "mem_kept1", 32'h8, 32'h002081B3, 1'b0);

    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
